// File: rtl/cr_cceip_64_support_df_demux.sv
// -----------------------------------------------------------------------------
// cr_cceip_64_support_df_demux
//
// Purpose:
//   One inbound AXI4-stream data path is steered, one whole frame at a time,
//   to outbound port 0 (toward the CRC-gen stage) or outbound port 1 (toward
//   the CRC-check stage). The route is taken from df_demux_sel on the first
//   beat of a frame and held until the tlast beat is accepted. Each outbound
//   port has a 1-deep registered output stage, so a beat accepted on the
//   inbound side appears on its port exactly one clock later, and the path
//   sustains one beat per clock while the downstream is ready.
//
// Ports:
//   clk              in   clock
//   rst_n            in   asynchronous active-low reset
//   df_demux_sel     in   route select: 0 -> ob0, 1 -> ob1 (sampled at frame start)
//   df_demux_ib_in   in   inbound stream (tvalid, tlast, tid, tstrb, tuser, tdata)
//   df_demux_ib_out  out  inbound tready
//   ob0_in           in   port-0 downstream tready
//   ob0_out          out  port-0 outbound stream (registered)
//   ob1_in           in   port-1 downstream tready
//   ob1_out          out  port-1 outbound stream (registered)
//   frm_cnt0         out  frames fully delivered on port 0 (saturating)
//   frm_cnt1         out  frames fully delivered on port 1 (saturating)
//   demux_idle       out  registered: no frame in progress and both outputs empty
//   sel_chg_err      out  1-cycle pulse: df_demux_sel moved away from the
//                         latched route while a frame was in progress
// -----------------------------------------------------------------------------

package cr_cceip_64_support_df_demux_pkg;

    // Data-path beat. tvalid travels with the payload so a whole beat can be
    // held in a single register.
    typedef struct packed {
        logic        tvalid;
        logic        tlast;
        logic [0:0]  tid;
        logic [7:0]  tstrb;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage : cr_cceip_64_support_df_demux_pkg


module cr_cceip_64_support_df_demux
    import cr_cceip_64_support_df_demux_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter bit SEL_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             df_demux_sel,
    input  axi4s_dp_bus_t    df_demux_ib_in,
    output axi4s_dp_rdy_t    df_demux_ib_out,
    input  axi4s_dp_rdy_t    ob0_in,
    output axi4s_dp_bus_t    ob0_out,
    input  axi4s_dp_rdy_t    ob1_in,
    output axi4s_dp_bus_t    ob1_out,
    output logic [CNT_W-1:0] frm_cnt0,
    output logic [CNT_W-1:0] frm_cnt1,
    output logic             demux_idle,
    output logic             sel_chg_err
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q,       state_d;
    logic              route_q,       route_d;
    logic              sel_prev_q,    sel_prev_d;
    logic              sel_chg_err_q, sel_chg_err_d;
    logic              demux_idle_q,  demux_idle_d;
    axi4s_dp_bus_t     ob0_q,         ob0_d;
    axi4s_dp_bus_t     ob1_q,         ob1_d;
    logic [CNT_W-1:0]  frm_cnt0_q,    frm_cnt0_d;
    logic [CNT_W-1:0]  frm_cnt1_q,    frm_cnt1_d;

    logic              route;      // route applied to the beat currently offered
    logic              ib_rdy;
    logic              ib_accept;
    logic              ob0_drain;
    logic              ob1_drain;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the if/else tree can leave a value unassigned and infer a latch.
        state_d       = state_q;
        route_d       = route_q;
        sel_prev_d    = df_demux_sel;
        ob0_d         = ob0_q;
        ob1_d         = ob1_q;
        frm_cnt0_d    = frm_cnt0_q;
        frm_cnt1_d    = frm_cnt1_q;

        // Between frames the select steers the offered beat directly; inside a
        // frame the route captured on its first beat is used.
        route = (state_q == ST_IDLE) ? df_demux_sel : route_q;

        // Inbound ready only looks at the port this beat is headed to, and never
        // at inbound tvalid, so a stalled idle port cannot block the other one.
        ib_rdy = route ? (!ob1_q.tvalid || ob1_in.tready)
                       : (!ob0_q.tvalid || ob0_in.tready);

        ib_accept = df_demux_ib_in.tvalid && ib_rdy;
        ob0_drain = ob0_q.tvalid && ob0_in.tready;
        ob1_drain = ob1_q.tvalid && ob1_in.tready;

        // Drain first, then load: a load in the same cycle as a drain simply
        // replaces the departing beat and tvalid stays high.
        if (ob0_drain) begin
            ob0_d = '0;
        end
        if (ob1_drain) begin
            ob1_d = '0;
        end
        if (ib_accept && !route) begin
            ob0_d        = df_demux_ib_in;
            ob0_d.tvalid = 1'b1;
        end
        if (ib_accept && route) begin
            ob1_d        = df_demux_ib_in;
            ob1_d.tvalid = 1'b1;
        end

        // Frame-atomic steering.
        if (ib_accept) begin
            if (df_demux_ib_in.tlast) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_IN_FRAME;
                route_d = route;
            end
        end

        // A frame is complete when its tlast beat leaves the output register.
        if (ob0_drain && ob0_q.tlast && (frm_cnt0_q != CNT_MAX)) begin
            frm_cnt0_d = frm_cnt0_q + CNT_W'(1);
        end
        if (ob1_drain && ob1_q.tlast && (frm_cnt1_q != CNT_MAX)) begin
            frm_cnt1_d = frm_cnt1_q + CNT_W'(1);
        end

        // Edge-only detection: flag the cycle the select first moves away from
        // the latched route, not every cycle it stays there.
        sel_chg_err_d = (state_q == ST_IN_FRAME) &&
                        (df_demux_sel != route_q) &&
                        (df_demux_sel != sel_prev_q);

        demux_idle_d = (state_q == ST_IDLE) && !ob0_q.tvalid && !ob1_q.tvalid;
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    // The output registers are fully reset (not just tvalid) so the payload
    // fields read as zero until the first beat is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            route_q       <= SEL_RST;
            sel_prev_q    <= SEL_RST;
            sel_chg_err_q <= 1'b0;
            demux_idle_q  <= 1'b0;
            ob0_q         <= '0;
            ob1_q         <= '0;
            frm_cnt0_q    <= '0;
            frm_cnt1_q    <= '0;
        end else begin
            state_q       <= state_d;
            route_q       <= route_d;
            sel_prev_q    <= sel_prev_d;
            sel_chg_err_q <= sel_chg_err_d;
            demux_idle_q  <= demux_idle_d;
            ob0_q         <= ob0_d;
            ob1_q         <= ob1_d;
            frm_cnt0_q    <= frm_cnt0_d;
            frm_cnt1_q    <= frm_cnt1_d;
        end
    end

    assign df_demux_ib_out.tready = ib_rdy;
    assign ob0_out                = ob0_q;
    assign ob1_out                = ob1_q;
    assign frm_cnt0               = frm_cnt0_q;
    assign frm_cnt1               = frm_cnt1_q;
    assign demux_idle             = demux_idle_q;
    assign sel_chg_err            = sel_chg_err_q;

endmodule : cr_cceip_64_support_df_demux
